// File: rtl/uart_rx_edge_bit_sampler.sv
// UART RX oversampling stage: edge/bit counters, 3-sample majority vote of each bit,
// and the start-bit glitch flag consumed by the RX control FSM.
module uart_rx_edge_bit_sampler #(
    parameter int unsigned PRESCALE = 8,
    parameter int unsigned EDGE_W   = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RX_in,
    input  logic              edge_bit_en,
    input  logic              dat_samp_en,
    input  logic              strt_chk_en,
    output logic [EDGE_W-1:0] edge_cnt,
    output logic [3:0]        bit_cnt,
    output logic              sampled_bit,
    output logic              samp_done,
    output logic              strt_glitch
);

    localparam int unsigned       BIT_W     = 4;
    localparam int unsigned       MID       = PRESCALE / 2;
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(PRESCALE - 1);
    localparam logic [EDGE_W-1:0] CAP0      = EDGE_W'(MID - 2);
    localparam logic [EDGE_W-1:0] CAP1      = EDGE_W'(MID - 1);
    localparam logic [EDGE_W-1:0] CAP2      = EDGE_W'(MID);
    localparam logic [BIT_W-1:0]  BIT_MAX   = BIT_W'(15);

    logic [EDGE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [BIT_W-1:0]  bit_cnt_q,  bit_cnt_d;
    logic              s0_q, s0_d;
    logic              s1_q, s1_d;
    logic              s2_q, s2_d;
    logic              sampled_bit_q, sampled_bit_d;
    logic              samp_done_q,   samp_done_d;

    // Next-state: counters, sample capture and majority update
    always_comb begin
        edge_cnt_d    = edge_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        s0_d          = s0_q;
        s1_d          = s1_q;
        s2_d          = s2_q;
        sampled_bit_d = sampled_bit_q;
        samp_done_d   = 1'b0;

        if (!edge_bit_en) begin
            edge_cnt_d = '0;
            bit_cnt_d  = '0;
        end else if (edge_cnt_q == EDGE_LAST) begin
            edge_cnt_d = '0;
            if (bit_cnt_q != BIT_MAX) begin
                bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end
        end else begin
            edge_cnt_d = edge_cnt_q + EDGE_W'(1);
        end

        if (dat_samp_en) begin
            if (edge_cnt_q == CAP0) begin
                s0_d = RX_in;
            end
            if (edge_cnt_q == CAP1) begin
                s1_d = RX_in;
            end
            // Third sample is voted in the same cycle it is captured
            if (edge_cnt_q == CAP2) begin
                s2_d          = RX_in;
                sampled_bit_d = (s0_q & s1_q) | (s0_q & s2_d) | (s1_q & s2_d);
                samp_done_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            edge_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            s0_q          <= 1'b1;
            s1_q          <= 1'b1;
            s2_q          <= 1'b1;
            sampled_bit_q <= 1'b1;
            samp_done_q   <= 1'b0;
        end else begin
            edge_cnt_q    <= edge_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            s0_q          <= s0_d;
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            sampled_bit_q <= sampled_bit_d;
            samp_done_q   <= samp_done_d;
        end
    end

    assign edge_cnt    = edge_cnt_q;
    assign bit_cnt     = bit_cnt_q;
    assign sampled_bit = sampled_bit_q;
    assign samp_done   = samp_done_q;

    // Settles after the mid-bit update so the FSM can test it at the last edge of bit 0
    assign strt_glitch = strt_chk_en & sampled_bit_q & (bit_cnt_q == BIT_W'(0))
                       & (edge_cnt_q > CAP2);

endmodule

// File: tb/tb_uart_rx_edge_bit_sampler.sv
// Directed bench for uart_rx_edge_bit_sampler: counter model checked every cycle,
// expected bit values queued at stimulus time and popped on each samp_done pulse.
module tb_uart_rx_edge_bit_sampler;

    localparam int unsigned PRESCALE = 8;
    localparam int unsigned EDGE_W   = 3;
    localparam int unsigned MID      = PRESCALE / 2;

    logic              CLK = 1'b0;
    logic              RST;
    logic              RX_in;
    logic              edge_bit_en;
    logic              dat_samp_en;
    logic              strt_chk_en;
    logic [EDGE_W-1:0] edge_cnt;
    logic [3:0]        bit_cnt;
    logic              sampled_bit;
    logic              samp_done;
    logic              strt_glitch;

    uart_rx_edge_bit_sampler #(.PRESCALE(PRESCALE), .EDGE_W(EDGE_W)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_in       (RX_in),
        .edge_bit_en (edge_bit_en),
        .dat_samp_en (dat_samp_en),
        .strt_chk_en (strt_chk_en),
        .edge_cnt    (edge_cnt),
        .bit_cnt     (bit_cnt),
        .sampled_bit (sampled_bit),
        .samp_done   (samp_done),
        .strt_glitch (strt_glitch)
    );

    always #5 CLK = ~CLK;

    int          nvec  = 0;
    int          nfail = 0;
    int          exp_edge = 0;
    int          exp_bit  = 0;
    int          n_samp   = 0;
    logic [9:0]  got_bits = '0;
    logic        exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the counter model, check counters and samples
    task automatic step(input logic rx, input logic ebe, input logic dse, input logic sce);
        logic want;
        RX_in       = rx;
        edge_bit_en = ebe;
        dat_samp_en = dse;
        strt_chk_en = sce;
        @(posedge CLK);
        #1;
        if (RST) begin
            exp_edge = 0;
            exp_bit  = 0;
        end else if (!ebe) begin
            exp_edge = 0;
            exp_bit  = 0;
        end else if (exp_edge == PRESCALE - 1) begin
            exp_edge = 0;
            if (exp_bit < 15) exp_bit++;
        end else begin
            exp_edge++;
        end
        chk("edge_cnt", 32'(edge_cnt), 32'(exp_edge));
        chk("bit_cnt", 32'(bit_cnt), 32'(exp_bit));
        if (samp_done === 1'b1) begin
            n_samp++;
            got_bits = {sampled_bit, got_bits[9:1]};
            chk("samp_edge", 32'(edge_cnt), 32'(MID + 1));
            if (exp_q.size() == 0) begin
                chk("samp_spurious", 32'(samp_done), 32'd0);
            end else begin
                want = exp_q.pop_front();
                chk("sampled_bit", 32'(sampled_bit), 32'(want));
            end
        end
    endtask

    // Frame: start, 8 data LSB first, stop; RX forced wrong at edge gl of every bit
    task automatic send_frame(input logic [7:0] d, input int gl);
        logic tb;
        int   n0;
        n0 = n_samp;
        for (int b = 0; b < 10; b++) begin
            tb = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : d[b-1];
            exp_q.push_back(tb);
            for (int e = 0; e < int'(PRESCALE); e++) begin
                step((e == gl) ? ~tb : tb, 1'b1, 1'b1, 1'b0);
            end
        end
        chk("samp_per_frame", 32'(n_samp - n0), 32'd10);
        chk("frame_byte", 32'(got_bits[8:1]), 32'(d));
        chk("frame_start", 32'(got_bits[0]), 32'd0);
    endtask

    initial begin
        RST = 1'b1;
        RX_in = 1'b1;
        edge_bit_en = 1'b0;
        dat_samp_en = 1'b0;
        strt_chk_en = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_edge", 32'(edge_cnt), 32'd0);
        chk("rst_bit", 32'(bit_cnt), 32'd0);
        chk("rst_sb", 32'(sampled_bit), 32'd1);
        chk("rst_done", 32'(samp_done), 32'd0);
        RST = 1'b0;

        // Counter wrap over 11 bit periods, no sampling
        for (int i = 0; i < 88; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("wrap_end_bit", 32'(bit_cnt), 32'd11);
        step(1'b1, 1'b0, 1'b0, 1'b0);

        // Saturation of bit_cnt at 15
        for (int i = 0; i < 8 * 20; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("sat_bit", 32'(bit_cnt), 32'd15);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("sat_clear", 32'(bit_cnt), 32'd0);

        // Majority vote with a one-clock glitch at edge 3 of each bit
        send_frame(8'hA5, int'(MID) - 1);
        step(1'b1, 1'b0, 1'b0, 1'b0);

        // Back-to-back frames with a single-cycle enable drop
        send_frame(8'h3C, -1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("b2b_edge", 32'(edge_cnt), 32'd0);
        chk("b2b_bit", 32'(bit_cnt), 32'd0);
        send_frame(8'h3C, -1);
        step(1'b1, 1'b0, 1'b0, 1'b0);

        // Glitch on the other two capture edges
        send_frame(8'h5A, int'(MID) - 2);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(8'hC3, int'(MID));
        step(1'b1, 1'b0, 1'b0, 1'b0);

        // Reset mid-count after sampled_bit has gone low
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("pre_rst_sb", 32'(sampled_bit), 32'd0);
        #2;
        RST = 1'b1;
        #1;
        chk("async_rst_edge", 32'(edge_cnt), 32'd0);
        chk("async_rst_bit", 32'(bit_cnt), 32'd0);
        chk("async_rst_sb", 32'(sampled_bit), 32'd1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
        RST = 1'b0;

        // False start: drive sampled_bit low first, then a short low pulse
        exp_q.push_back(1'b0);
        for (int i = 0; i < int'(PRESCALE); i++) step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("fs_pre_sb", 32'(sampled_bit), 32'd0);
        exp_q.push_back(1'b1);
        for (int i = 0; i < int'(PRESCALE); i++) begin
            step((i < 2) ? 1'b0 : 1'b1, 1'b1, 1'b1, 1'b1);
            chk("strt_glitch", 32'(strt_glitch),
                32'((exp_bit == 0) && (exp_edge > int'(MID))));
        end
        chk("fs_sb", 32'(sampled_bit), 32'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
